// File: rtl/synth_pkg.sv
// Shared constants for the synth update-clock generator: channel modes and divider defaults.
// Pure declarations; no logic, no latency, no flow control.
// Used by synth_clk_ch and synth_clk_gen.
package synth_pkg;

    localparam logic MODE_SQUARE     = 1'b0;
    localparam logic MODE_STROBE     = 1'b1;
    localparam int   SYN_DIV_W       = 16;
    localparam int   SYN_DEFAULT_DIV = 50;

endpackage

// File: rtl/synth_clk_ch.sv
// One update-clock channel: half-period counter with shadowed divider, square/strobe output.
// Outputs registered, first terminal div cycles after enable; no backpressure (Syn_ce freezes state).
// SYNTH_CLK_SYNC_EN adds a sync restart input that phase-aligns the channel.
module synth_clk_ch
    import synth_pkg::*;
#(
    parameter int DIV_W       = SYN_DIV_W,
    parameter int DEFAULT_DIV = SYN_DEFAULT_DIV
) (
    input  logic             Sys_clk,
    input  logic             Syn_rst,
    input  logic             Syn_ce,
    input  logic             en,
    input  logic             mode,
    input  logic             wr,
    input  logic [DIV_W-1:0] val,
`ifdef SYNTH_CLK_SYNC_EN
    input  logic             sync,
`endif
    output logic             syn_clk,
    output logic             syn_tick,
    output logic             div_pend
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] shd_div;
    logic [DIV_W-1:0] wr_div;
    logic             terminal;
    logic             restart;

    // A written zero behaves as one, so act_div never underflows below.
    assign wr_div   = (val == '0) ? DIV_W'(1) : val;
    assign terminal = (cnt >= act_div - DIV_W'(1));
`ifdef SYNTH_CLK_SYNC_EN
    assign restart  = !en || sync;
`else
    assign restart  = !en;
`endif

    always_ff @(posedge Sys_clk or posedge Syn_rst) begin
        if (Syn_rst) begin
            cnt      <= '0;
            act_div  <= DIV_W'(DEFAULT_DIV);
            shd_div  <= DIV_W'(DEFAULT_DIV);
            div_pend <= 1'b0;
            syn_clk  <= 1'b0;
            syn_tick <= 1'b0;
        end else if (!Syn_ce) begin
            syn_tick <= 1'b0;
            if (wr) begin
                shd_div  <= wr_div;
                div_pend <= 1'b1;
            end
        end else if (restart || terminal) begin
            // Period boundary: a same-cycle write wins over an older pending shadow.
            if (wr) begin
                act_div <= wr_div;
                shd_div <= wr_div;
            end else if (div_pend) begin
                act_div <= shd_div;
            end
            div_pend <= 1'b0;
            cnt      <= '0;
            if (restart) begin
                syn_clk  <= 1'b0;
                syn_tick <= 1'b0;
            end else begin
                syn_clk  <= (mode == MODE_STROBE) ? 1'b0 : ~syn_clk;
                syn_tick <= 1'b1;
            end
        end else begin
            cnt      <= cnt + DIV_W'(1);
            syn_tick <= 1'b0;
            if (wr) begin
                shd_div  <= wr_div;
                div_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/synth_clk_gen.sv
// Multi-channel programmable update-clock generator for the AC97 synth (one synth_clk_ch per channel).
// Outputs registered per channel; no backpressure, Syn_ce globally freezes all channels.
// SYNTH_CLK_SYNC_EN adds Sync_in, which restarts all enabled channels together.
module synth_clk_gen
    import synth_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = SYN_DIV_W,
    parameter int DEFAULT_DIV = SYN_DEFAULT_DIV,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Sys_clk,
    input  logic              Syn_rst,
    input  logic              Syn_ce,
    input  logic [NUM_CH-1:0] Ch_en,
    input  logic [NUM_CH-1:0] Ch_mode,
    input  logic              Div_wr,
    input  logic [SEL_W-1:0]  Div_sel,
    input  logic [DIV_W-1:0]  Div_val,
`ifdef SYNTH_CLK_SYNC_EN
    input  logic              Sync_in,
`endif
    output logic [NUM_CH-1:0] Syn_clk,
    output logic [NUM_CH-1:0] Syn_tick,
    output logic [NUM_CH-1:0] Div_pend
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_hit;

        // Selects beyond NUM_CH match no channel and are dropped.
        assign wr_hit = Div_wr && (int'(Div_sel) == i);

        synth_clk_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .Sys_clk  (Sys_clk),
            .Syn_rst  (Syn_rst),
            .Syn_ce   (Syn_ce),
            .en       (Ch_en[i]),
            .mode     (Ch_mode[i]),
            .wr       (wr_hit),
            .val      (Div_val),
`ifdef SYNTH_CLK_SYNC_EN
            .sync     (Sync_in),
`endif
            .syn_clk  (Syn_clk[i]),
            .syn_tick (Syn_tick[i]),
            .div_pend (Div_pend[i])
        );
    end

endmodule
